irq_regf: RTL and testbench
===========================

Name: irq_regf

Overview:
- Parametrised interrupt-controller register file; next generation of the generated register-file blocks.
- Adds to the plain RW/RO/RC word types:
  - NUM_CH interrupt sources with per-channel edge/level detection;
  - sticky write-1-to-clear status, enable mask, saturating per-channel event counters;
  - a registered interrupt output;
  - a registered one-cycle read response with byte-select writes.
- Sits on the same mem_* bus as other register files; irq_o routes to the system interrupt aggregator.

Parameters:
- NUM_CH, 8, number of interrupt channels (1..32).
- CNT_W, 16, event counter width (1..32); read value zero-extended to 32 bits.
- ADDR_W, 13, byte address width; must cover 4*(4+NUM_CH) bytes.

Ports:
- main_clk_i  in  1  clock.
- main_rst_an_i  in  1  asynchronous reset, active-low.
- mem_ena_i  in  1  bus request, single-cycle.
- mem_addr_i  in  ADDR_W  byte address.
- mem_wena_i  in  1  1=write, 0=read.
- mem_wdata_i  in  32  write data.
- mem_sel_i  in  4  byte selects for writes.
- mem_rdata_o  out  32  read data, registered.
- mem_rvld_o  out  1  response valid, one cycle after every request (read or write).
- mem_err_o  out  1  error, qualified by mem_rvld_o.
- irq_src_i  in  NUM_CH  interrupt sources, synchronous to main_clk_i.
- irq_o  out  1  registered OR of (status & enable).

Behaviour:
- Reset (main_rst_an_i=0, asynchronous):
  - all storage cleared: status, enable, mode, counters, source-history register;
  - all outputs 0: mem_rdata_o, mem_rvld_o, mem_err_o, irq_o.
  - Reset mid-transaction discards the pending response; no rvld after reset release.
- Address map (word index = addr[ADDR_W-1:2]):
  - 0 STATUS W1C;
  - 1 ENABLE RW;
  - 2 MODE RW (bit i: 0=level, 1=rising edge);
  - 3 RAW RO (irq_src_i);
  - 4+i CNT[i] RO, write clears, for i in 0..NUM_CH-1.
  - Bits above NUM_CH-1 read 0 and ignore writes.
- Errors:
  - mem_err_o=1 on addr[1:0]!=0 or index >= 4+NUM_CH; the access then has no effect and rdata=0.
  - Writes to RAW respond with mem_err_o=0 and no effect.
- Bus response timing: request in cycle N -> mem_rvld_o=1, mem_rdata_o, mem_err_o in cycle N+1.
  - Writes return rdata=0.
  - Back-to-back requests are allowed every cycle.
  - Outside response cycles, mem_rdata_o=0 and mem_err_o=0.
- Byte selects:
  - ENABLE, MODE: byte k updated only when mem_sel_i[k]=1.
  - STATUS: clear bit i when wdata[i]=1 and the select of its byte is 1.
  - CNT clear: fires if any mem_sel_i bit is 1.
- Event detection:
  - prev register holds last-cycle irq_src_i (resets to 0).
  - rise[i] = irq_src_i[i] & ~prev[i].
  - event[i] = MODE[i] ? rise[i] : irq_src_i[i].
  - A source high at reset release counts as a rise.
- STATUS:
  - set when event[i]=1; cleared only by W1C.
  - Same-cycle set and W1C clear: set wins (bit stays 1).
- CNT[i]:
  - increments on rise[i] in both modes; saturates at 2^CNT_W-1 (no wrap).
  - Same-cycle clear and rise: result 1.
  - Same-cycle clear with no rise: 0.
- irq_o:
  - registered |(STATUS_next & ENABLE_next).
  - Asserts the cycle after the event is captured in STATUS.
  - Deasserts the cycle after the W1C or enable-clear write takes effect.
- Reads are non-destructive and return pre-update values for writes in the same cycle (no forwarding).

Decomposition:
- Package irq_regf_pkg:
  - word index constants STATUS_IDX=0, ENABLE_IDX=1, MODE_IDX=2, RAW_IDX=3, CNT_BASE_IDX=4;
  - enum irq_mode_e {IRQ_LEVEL, IRQ_EDGE};
  - function for CNT_W saturation.
- Sub-module irq_regf_chan, instantiated NUM_CH times:
  - contains prev flop, event logic, status bit, saturating counter;
  - inputs: src, mode, w1c, cnt_clr;
  - outputs: status, cnt.
- Top holds address decode, ENABLE/MODE storage, read mux, response register, irq_o flop.

Test Plan:
- Reset:
  - Stimulus: hold main_rst_an_i=0 while irq_src_i=all-ones.
  - Response: all outputs 0.
  - Stimulus: release reset with MODE=0.
  - Response: STATUS=0xFF after 1 cycle; irq_o stays 0 because ENABLE=0.
- Edge mode and counter:
  - Stimulus: MODE=0x01, ENABLE=0x01; pulse irq_src_i[0] high 3 cycles, 3 times.
  - Response: STATUS[0]=1; CNT[0] (addr 0x10) reads 3; irq_o=1 two cycles after the first rise.
- W1C vs event collision:
  - Stimulus: write STATUS=0x01 in the same cycle as rise on channel 0.
  - Response: STATUS[0] stays 1; irq_o stays 1.
  - Stimulus: repeat the write without an event.
  - Response: STATUS[0]=0; irq_o=0 the next cycle.
- Saturation and clear:
  - Stimulus: CNT_W=4; apply 20 rises on channel 1.
  - Response: CNT[1] reads 0xF.
  - Stimulus: write 0x0 to addr 0x14 with sel=0x1 coincident with a rise.
  - Response: CNT[1] reads 1.
- Byte selects:
  - Stimulus: NUM_CH=32; write ENABLE=0xFFFFFFFF with sel=0x4.
  - Response: readback 0x00FF0000.
- Errors:
  - Stimulus: read addr 0x2 and addr 4*(4+NUM_CH).
  - Response: mem_rvld_o=1, mem_err_o=1, rdata=0.
  - Stimulus: back-to-back read sequence 0x0, 0x4, 0x8.
  - Response: three consecutive rvld cycles with correct data.

Source files
------------

// File: rtl/irq_regf_pkg.sv
// irq_regf_pkg: shared definitions for the interrupt-controller register file.
//   - word index constants of the register map
//   - irq_mode_e: per-channel detection mode
//   - cnt_max(): all-ones value of an event counter of a given width
package irq_regf_pkg;

  localparam int STATUS_IDX   = 0;
  localparam int ENABLE_IDX   = 1;
  localparam int MODE_IDX     = 2;
  localparam int RAW_IDX      = 3;
  localparam int CNT_BASE_IDX = 4;

  typedef enum logic {
    IRQ_LEVEL = 1'b0,
    IRQ_EDGE  = 1'b1
  } irq_mode_e;

  // Saturation value of a w-bit counter, returned in 32 bits.
  function automatic logic [31:0] cnt_max(input int w);
    if (w >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/irq_regf_if.sv
// irq_regf_if: mem_* register bus.
//   Handshake: a request is a single cycle with mem_ena_i=1 (no ready; the
//   slave accepts every request, back-to-back allowed). Exactly one cycle
//   later the slave drives mem_rvld_o=1 with mem_rdata_o/mem_err_o; both are
//   0 whenever mem_rvld_o=0. Writes return rdata=0.
//   slave  modport: register file side.
//   master modport: bus requester side.
interface irq_regf_if #(
  parameter int ADDR_W = 13
);
  logic              mem_ena_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic              mem_wena_i;
  logic [31:0]       mem_wdata_i;
  logic [3:0]        mem_sel_i;
  logic [31:0]       mem_rdata_o;
  logic              mem_rvld_o;
  logic              mem_err_o;

  modport slave (
    input  mem_ena_i, mem_addr_i, mem_wena_i, mem_wdata_i, mem_sel_i,
    output mem_rdata_o, mem_rvld_o, mem_err_o
  );

  modport master (
    output mem_ena_i, mem_addr_i, mem_wena_i, mem_wdata_i, mem_sel_i,
    input  mem_rdata_o, mem_rvld_o, mem_err_o
  );
endinterface

// File: rtl/irq_regf_chan.sv
// irq_regf_chan: one interrupt channel.
//   clk_i, rst_an_i : clock, async active-low reset
//   src_i           : interrupt source (synchronous)
//   mode_i          : level or rising-edge detection for the status bit
//   w1c_i           : clear request for the status bit
//   cnt_clr_i       : clear request for the event counter
//   status_o        : sticky status bit (registered)
//   status_nxt_o    : next value of the status bit (feeds the irq flop)
//   cnt_o           : saturating rise counter
module irq_regf_chan
  import irq_regf_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_an_i,
  input  logic             src_i,
  input  irq_mode_e        mode_i,
  input  logic             w1c_i,
  input  logic             cnt_clr_i,
  output logic             status_o,
  output logic             status_nxt_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [31:0]      CNT_MAX_W = cnt_max(CNT_W);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_MAX_W[CNT_W-1:0];

  logic             prev_q, prev_d;
  logic             status_q, status_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise;
  logic             evt;

  always_comb begin
    prev_d   = src_i;
    // prev resets to 0, so a source already high at reset release is a rise.
    rise     = src_i & ~prev_q;
    evt      = (mode_i == IRQ_EDGE) ? rise : src_i;
    // A new event wins over a simultaneous clear.
    status_d = evt | (status_q & ~w1c_i);
    cnt_d    = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = rise ? CNT_W'(1) : '0;
    end else if (rise && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      prev_q   <= 1'b0;
      status_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      prev_q   <= prev_d;
      status_q <= status_d;
      cnt_q    <= cnt_d;
    end
  end

  assign status_o     = status_q;
  assign status_nxt_o = status_d;
  assign cnt_o        = cnt_q;

endmodule

// File: rtl/irq_regf.sv
// irq_regf: interrupt-controller register file on the mem_* bus.
//   main_clk_i, main_rst_an_i : clock, async active-low reset
//   bus                       : mem_* slave port (irq_regf_if.slave)
//   irq_src_i                 : NUM_CH interrupt sources
//   irq_o                     : registered OR of (status & enable)
// Map (word index): 0 STATUS W1C, 1 ENABLE RW, 2 MODE RW, 3 RAW RO,
// 4+i CNT[i] RO with write-to-clear.
module irq_regf
  import irq_regf_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 13
) (
  input  logic              main_clk_i,
  input  logic              main_rst_an_i,
  irq_regf_if.slave         bus,
  input  logic [NUM_CH-1:0] irq_src_i,
  output logic              irq_o
);

  logic [31:0]       idx;
  logic              addr_err, wr_ok, rd_ok;
  logic [31:0]       wmask, en_wr, mode_wr, w1c_wr;
  logic [NUM_CH-1:0] enable_q, enable_d;
  logic [NUM_CH-1:0] mode_q, mode_d;
  logic [NUM_CH-1:0] status, status_nxt, w1c, cnt_clr;
  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [31:0]       rdata_q, rdata_d;
  logic              rvld_q, rvld_d, err_q, err_d, irq_q, irq_d;
  // Merged words are computed at full bus width; bits above NUM_CH are dropped.
  logic              unused_hi;

  assign unused_hi = ^{en_wr, mode_wr, w1c_wr};

  always_comb begin
    idx      = 32'(bus.mem_addr_i[ADDR_W-1:2]);
    addr_err = (bus.mem_addr_i[1:0] != 2'b00) || (idx >= 32'(CNT_BASE_IDX + NUM_CH));
    wr_ok    = bus.mem_ena_i & bus.mem_wena_i & ~addr_err;
    rd_ok    = bus.mem_ena_i & ~bus.mem_wena_i & ~addr_err;
    wmask    = {{8{bus.mem_sel_i[3]}}, {8{bus.mem_sel_i[2]}},
                {8{bus.mem_sel_i[1]}}, {8{bus.mem_sel_i[0]}}};
    en_wr    = (32'(enable_q) & ~wmask) | (bus.mem_wdata_i & wmask);
    mode_wr  = (32'(mode_q) & ~wmask) | (bus.mem_wdata_i & wmask);
    w1c_wr   = bus.mem_wdata_i & wmask;

    enable_d = enable_q;
    if (wr_ok && (idx == 32'(ENABLE_IDX))) enable_d = en_wr[NUM_CH-1:0];
    mode_d = mode_q;
    if (wr_ok && (idx == 32'(MODE_IDX))) mode_d = mode_wr[NUM_CH-1:0];
    w1c = '0;
    if (wr_ok && (idx == 32'(STATUS_IDX))) w1c = w1c_wr[NUM_CH-1:0];
    cnt_clr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_clr[i] = wr_ok && (idx == 32'(CNT_BASE_IDX + i)) && (|bus.mem_sel_i);
    end

    // Read mux samples current register values (no write forwarding).
    rdata_d = '0;
    if (rd_ok) begin
      if (idx == 32'(STATUS_IDX)) rdata_d = 32'(status);
      if (idx == 32'(ENABLE_IDX)) rdata_d = 32'(enable_q);
      if (idx == 32'(MODE_IDX))   rdata_d = 32'(mode_q);
      if (idx == 32'(RAW_IDX))    rdata_d = 32'(irq_src_i);
      for (int i = 0; i < NUM_CH; i++) begin
        if (idx == 32'(CNT_BASE_IDX + i)) rdata_d = 32'(cnt[i]);
      end
    end
    rvld_d = bus.mem_ena_i;
    err_d  = bus.mem_ena_i & addr_err;
    irq_d  = |(status_nxt & enable_d);
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    irq_regf_chan #(.CNT_W(CNT_W)) u_ch (
      .clk_i        (main_clk_i),
      .rst_an_i     (main_rst_an_i),
      .src_i        (irq_src_i[i]),
      .mode_i       (irq_mode_e'(mode_q[i])),
      .w1c_i        (w1c[i]),
      .cnt_clr_i    (cnt_clr[i]),
      .status_o     (status[i]),
      .status_nxt_o (status_nxt[i]),
      .cnt_o        (cnt[i])
    );
  end

  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      enable_q <= '0;
      mode_q   <= '0;
      rdata_q  <= '0;
      rvld_q   <= 1'b0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      enable_q <= enable_d;
      mode_q   <= mode_d;
      rdata_q  <= rdata_d;
      rvld_q   <= rvld_d;
      err_q    <= err_d;
      irq_q    <= irq_d;
    end
  end

  assign bus.mem_rdata_o = rdata_q;
  assign bus.mem_rvld_o  = rvld_q;
  assign bus.mem_err_o   = err_q;
  assign irq_o           = irq_q;

endmodule

// File: tb/tb_irq_regf.sv
// tb_irq_regf: directed bench for irq_regf (NUM_CH=32, CNT_W=4).
// Bus requests push expected responses into exp_q/exp_err_q; an independent
// monitor pops and compares whenever mem_rvld_o is seen.
module tb_irq_regf;
  localparam int NUM_CH = 32;
  localparam int CNT_W  = 4;
  localparam int ADDR_W = 13;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_CH-1:0] src;
  logic              irq;

  irq_regf_if #(.ADDR_W(ADDR_W)) bus ();

  irq_regf #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .main_clk_i    (clk),
    .main_rst_an_i (rst_n),
    .bus           (bus),
    .irq_src_i     (src),
    .irq_o         (irq)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  int          n_pass = 0;
  int          n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; leaves the request up for one cycle.
  task automatic bus_req(input logic we, input int a, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] exp_d, input logic exp_e);
    bus.mem_ena_i   = 1'b1;
    bus.mem_wena_i  = we;
    bus.mem_addr_i  = ADDR_W'(a);
    bus.mem_wdata_i = d;
    bus.mem_sel_i   = s;
    exp_q.push_back(exp_d);
    exp_err_q.push_back(exp_e);
    @(negedge clk);
    bus.mem_ena_i   = 1'b0;
    bus.mem_wena_i  = 1'b0;
    bus.mem_wdata_i = '0;
    bus.mem_sel_i   = '0;
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] s, input logic exp_e);
    bus_req(1'b1, a, d, s, 32'h0, exp_e);
  endtask

  task automatic rd(input int a, input logic [31:0] exp_d);
    bus_req(1'b0, a, 32'h0, 4'h0, exp_d, 1'b0);
  endtask

  task automatic rd_err(input int a);
    bus_req(1'b0, a, 32'h0, 4'h0, 32'h0, 1'b1);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_rvld_o) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_rvld: got rvld=1 expected no response");
        end else begin
          check("rdata", bus.mem_rdata_o, exp_q.pop_front());
          check_bit("err", bus.mem_err_o, exp_err_q.pop_front());
        end
      end else begin
        check("idle_rdata", bus.mem_rdata_o, 32'h0);
        check_bit("idle_err", bus.mem_err_o, 1'b0);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within budget");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.mem_ena_i   = 1'b0;
    bus.mem_wena_i  = 1'b0;
    bus.mem_addr_i  = '0;
    bus.mem_wdata_i = '0;
    bus.mem_sel_i   = '0;
    src             = '1;

    // Reset with all sources high.
    repeat (3) @(negedge clk);
    check("rst_rdata", bus.mem_rdata_o, 32'h0);
    check_bit("rst_rvld", bus.mem_rvld_o, 1'b0);
    check_bit("rst_err", bus.mem_err_o, 1'b0);
    check_bit("rst_irq", irq, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_bit("irq_enable_off", irq, 1'b0);
    rd(0, 32'hFFFF_FFFF);

    // Clean slate: sources low, clear status and the counters used below.
    src = '0;
    wr(0, 32'hFFFF_FFFF, 4'hF, 1'b0);
    wr(32'h10, 32'h0, 4'h1, 1'b0);
    wr(32'h14, 32'h0, 4'h1, 1'b0);
    rd(0, 32'h0);

    // Edge mode on channel 0 with counter.
    wr(32'h8, 32'h1, 4'hF, 1'b0);
    wr(32'h4, 32'h1, 4'hF, 1'b0);
    check_bit("irq_before_pulse", irq, 1'b0);
    for (int p = 0; p < 3; p++) begin
      src[0] = 1'b1;
      repeat (2) @(negedge clk);
      if (p == 0) check_bit("irq_after_rise", irq, 1'b1);
      @(negedge clk);
      src[0] = 1'b0;
      repeat (2) @(negedge clk);
    end
    rd(32'h10, 32'h3);
    rd(0, 32'h1);
    check_bit("irq_held", irq, 1'b1);

    // W1C colliding with a rise: set wins.
    src[0] = 1'b1;
    wr(0, 32'h1, 4'h1, 1'b0);
    check_bit("irq_collision", irq, 1'b1);
    rd(0, 32'h1);
    wr(0, 32'h1, 4'h1, 1'b0);
    check_bit("irq_cleared", irq, 1'b0);
    rd(0, 32'h0);
    src[0] = 1'b0;

    // Counter saturation on channel 1, then clear coincident with a rise.
    for (int k = 0; k < 20; k++) begin
      src[1] = 1'b1;
      @(negedge clk);
      src[1] = 1'b0;
      @(negedge clk);
    end
    rd(32'h14, 32'hF);
    src[1] = 1'b1;
    wr(32'h14, 32'h0, 4'h1, 1'b0);
    src[1] = 1'b0;
    rd(32'h14, 32'h1);

    // Byte selects.
    wr(32'h4, 32'h0, 4'hF, 1'b0);
    wr(32'h4, 32'hFFFF_FFFF, 4'h4, 1'b0);
    rd(32'h4, 32'h00FF_0000);
    wr(32'h8, 32'hAABB_CCDD, 4'h9, 1'b0);
    rd(32'h8, 32'hAA00_00DD);

    // RAW read and ignored RAW write; bits 16..19 are level-mode and enabled.
    src = 32'h0F0F_5A5A;
    rd(32'hC, 32'h0F0F_5A5A);
    wr(32'hC, 32'hFFFF_FFFF, 4'hF, 1'b0);
    src = '0;
    check_bit("irq_level_enabled", irq, 1'b1);
    wr(32'h4, 32'h0, 4'hF, 1'b0);
    check_bit("irq_enable_clear", irq, 1'b0);
    wr(32'h4, 32'hFFFF_FFFF, 4'h4, 1'b0);
    wr(0, 32'hFFFF_FFFF, 4'hF, 1'b0);

    // One-cycle level pulse on channel 8, then back-to-back reads.
    src[8] = 1'b1;
    @(negedge clk);
    src[8] = 1'b0;
    rd(0, 32'h0000_0100);
    rd(32'h4, 32'h00FF_0000);
    rd(32'h8, 32'hAA00_00DD);

    // Errors: misaligned, out of range, erroneous write has no effect.
    rd_err(32'h2);
    rd_err(4 * (4 + NUM_CH));
    wr(32'h6, 32'hFFFF_FFFF, 4'hF, 1'b1);
    rd(32'h4, 32'h00FF_0000);

    // Reset while a response is pending: it must be dropped.
    bus.mem_ena_i  = 1'b1;
    bus.mem_wena_i = 1'b0;
    bus.mem_addr_i = '0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.mem_ena_i = 1'b0;
    #1;
    check_bit("rvld_dropped", bus.mem_rvld_o, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rd(0, 32'h0);
    rd(32'h4, 32'h0);
    rd(32'h8, 32'h0);
    rd(32'h14, 32'h0);
    check_bit("irq_after_reset", irq, 1'b0);

    repeat (2) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
